// File: rtl/spi_slave_byte_interface_pkg.sv
// Shared constants for the SPI slave byte front end: default word size,
// FSM encoding and the SPI clock mode this front end is built for.
package spi_slave_byte_interface_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_slave_byte_interface_if.sv
// SPI pin and byte-side bundle; slave modport is the front end, master modport
// is whatever drives the pins and consumes the received bytes.
interface spi_slave_byte_interface_if
  import spi_slave_byte_interface_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  sclk;
  logic                  cs;
  logic                  mosi;
  logic                  miso;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  frame_active;

  modport slave (
    input  sclk, cs, mosi, tx_data,
    output miso, data_out, data_valid, frame_active
  );

  modport master (
    output sclk, cs, mosi, tx_data,
    input  miso, data_out, data_valid, frame_active
  );
endinterface

// File: rtl/spi_slave_byte_interface_sync.sv
// Single-bit multi-flop synchroniser for a raw SPI pin; latency SYNC_STAGES clk,
// reset value selectable so an idle chip select comes out of reset deasserted.
module spi_input_synchronizer #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/spi_slave_byte_interface.sv
// SPI mode-0 slave: oversampled pins, MSB-first byte deserialiser/serialiser.
// data_valid rises SYNC_STAGES+1 clk after the last sclk rise; no backpressure.
module spi_slave_byte_interface
  import spi_slave_byte_interface_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input logic                          clk,
  input logic                          reset,
  spi_slave_byte_interface_if.slave    bus
);
  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic sclk_s, cs_s, mosi_s;
  logic sclk_d_q, cs_d_q;
  logic sclk_rise, sclk_fall, cs_fall;
  logic sample_edge, shift_edge;

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-2:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-2:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  miso_q, miso_d;
  logic                  frame_active_q, frame_active_d;
  logic                  reload_q, reload_d;

  spi_input_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .d_i(bus.sclk), .q_o(sclk_s)
  );
  spi_input_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .d_i(bus.cs), .q_o(cs_s)
  );
  spi_input_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d_i(bus.mosi), .q_o(mosi_s)
  );

  assign sclk_rise = sclk_s & ~sclk_d_q;
  assign sclk_fall = ~sclk_s & sclk_d_q;
  assign cs_fall   = ~cs_s & cs_d_q;

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling one.
  assign sample_edge = (SPI_CPOL ^ SPI_CPHA) ? sclk_fall : sclk_rise;
  assign shift_edge  = (SPI_CPOL ^ SPI_CPHA) ? sclk_rise : sclk_fall;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    rx_shift_d     = rx_shift_q;
    tx_shift_d     = tx_shift_q;
    data_out_d     = data_out_q;
    data_valid_d   = 1'b0;
    miso_d         = miso_q;
    frame_active_d = frame_active_q;
    reload_d       = reload_q;

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        miso_d    = 1'b0;
        if (cs_fall) begin
          state_d        = ST_ACTIVE;
          tx_shift_d     = bus.tx_data[DATA_WIDTH-2:0];
          miso_d         = bus.tx_data[DATA_WIDTH-1];
          frame_active_d = 1'b1;
          reload_d       = 1'b0;
        end
      end
      default: begin
        // Chip select release wins over a byte completing in the same cycle.
        if (cs_s) begin
          state_d        = ST_IDLE;
          bit_cnt_d      = '0;
          miso_d         = 1'b0;
          frame_active_d = 1'b0;
          reload_d       = 1'b0;
        end else if (sample_edge) begin
          rx_shift_d = {rx_shift_q[DATA_WIDTH-3:0], mosi_s};
          if (bit_cnt_q == CNT_LAST) begin
            bit_cnt_d    = '0;
            data_out_d   = {rx_shift_q, mosi_s};
            data_valid_d = 1'b1;
            reload_d     = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (shift_edge) begin
          if (reload_q) begin
            tx_shift_d = bus.tx_data[DATA_WIDTH-2:0];
            miso_d     = bus.tx_data[DATA_WIDTH-1];
            reload_d   = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-3:0], 1'b0};
            miso_d     = tx_shift_q[DATA_WIDTH-2];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_d_q       <= 1'b0;
      cs_d_q         <= 1'b1;
      state_q        <= ST_IDLE;
      bit_cnt_q      <= '0;
      rx_shift_q     <= '0;
      tx_shift_q     <= '0;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      miso_q         <= 1'b0;
      frame_active_q <= 1'b0;
      reload_q       <= 1'b0;
    end else begin
      sclk_d_q       <= sclk_s;
      cs_d_q         <= cs_s;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_shift_q     <= rx_shift_d;
      tx_shift_q     <= tx_shift_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      miso_q         <= miso_d;
      frame_active_q <= frame_active_d;
      reload_q       <= reload_d;
    end
  end

  assign bus.miso         = miso_q;
  assign bus.data_out     = data_out_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.frame_active = frame_active_q;
endmodule

// File: tb/tb_spi_slave_byte_interface.sv
// Directed bench for the SPI slave front end: sclk runs at clk/8, the bench
// plays the SPI master and checks received bytes, miso read-back and resets.
module tb_spi_slave_byte_interface;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  spi_slave_byte_interface_if #(.DATA_WIDTH(8)) bus ();

  spi_slave_byte_interface #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         dv_count = 0;
  logic       dv_prev  = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_next  = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Passive byte collector; also guards that every pulse is one clk wide.
  always @(posedge clk) begin
    #1;
    if (reset && bus.data_valid) begin
      check_eq("dv_single_cycle", 32'(dv_prev), 32'h0);
      dv_count++;
      rx_q.push_back(bus.data_out);
    end
    dv_prev = bus.data_valid;
  end

  task automatic send_bits(input logic [7:0] b, input int nbits,
                           output logic [7:0] miso_b, output int lat);
    miso_b = 8'h00;
    lat    = -1;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = b[7-i];
      repeat (4) @(negedge clk);
      bus.sclk     = 1'b1;
      miso_b[7-i]  = bus.miso;
      for (int k = 1; k <= 4; k++) begin
        @(posedge clk);
        #1;
        if (bus.data_valid && lat < 0) begin
          lat         = k;
          bus.tx_data = tx_next;
        end
      end
      @(negedge clk);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic frame_start();
    @(negedge clk);
    bus.cs = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (8) @(negedge clk);
    bus.cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] mb;
    logic [7:0] burst [4];
    int         lat;
    int         base;
    int         qbase;

    burst[0] = 8'h05; burst[1] = 8'hA0; burst[2] = 8'h3C; burst[3] = 8'h05;
    bus.sclk    = 1'b0;
    bus.cs      = 1'b1;
    bus.mosi    = 1'b0;
    bus.tx_data = 8'h00;

    #1;
    check_eq("rst_data_out", 32'(bus.data_out), 32'h00);
    check_eq("rst_data_valid", 32'(bus.data_valid), 32'h0);
    check_eq("rst_miso", 32'(bus.miso), 32'h0);
    check_eq("rst_frame_active", 32'(bus.frame_active), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte 0x01, latency from the 8th sclk rise.
    base = dv_count;
    frame_start();
    check_eq("frame_active_on", 32'(bus.frame_active), 32'h1);
    send_bits(8'h01, 8, mb, lat);
    repeat (4) @(negedge clk);
    check_eq("b1_pulse_count", 32'(dv_count - base), 32'd1);
    check_eq("b1_data_out", 32'(bus.data_out), 32'h01);
    check_eq("b1_latency", 32'(lat), 32'd3);
    frame_end();
    check_eq("frame_active_off", 32'(bus.frame_active), 32'h0);
    check_eq("idle_miso", 32'(bus.miso), 32'h0);

    // Four back-to-back bytes in one frame.
    base  = dv_count;
    qbase = rx_q.size();
    frame_start();
    for (int i = 0; i < 4; i++) send_bits(burst[i], 8, mb, lat);
    frame_end();
    check_eq("burst_pulse_count", 32'(dv_count - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (rx_q.size() > qbase + i) check_eq($sformatf("burst_byte%0d", i), 32'(rx_q[qbase+i]), 32'(burst[i]));
      else check_eq($sformatf("burst_byte%0d_missing", i), 32'(rx_q.size()), 32'(qbase + i + 1));
    end

    // miso read-back with reload after the first byte.
    bus.tx_data = 8'hA5;
    tx_next     = 8'h5A;
    frame_start();
    send_bits(8'h11, 8, mb, lat);
    check_eq("miso_byte0", 32'(mb), 32'hA5);
    send_bits(8'h22, 8, mb, lat);
    check_eq("miso_byte1", 32'(mb), 32'h5A);
    frame_end();
    check_eq("rd_data_out", 32'(bus.data_out), 32'h22);

    // Abort after 5 bits, then a clean byte.
    tx_next = bus.tx_data;
    base    = dv_count;
    frame_start();
    send_bits(8'hFF, 5, mb, lat);
    frame_end();
    check_eq("abort_no_pulse", 32'(dv_count - base), 32'd0);
    check_eq("abort_data_kept", 32'(bus.data_out), 32'h22);
    frame_start();
    send_bits(8'h09, 8, mb, lat);
    repeat (4) @(negedge clk);
    check_eq("post_abort_count", 32'(dv_count - base), 32'd1);
    check_eq("post_abort_data", 32'(bus.data_out), 32'h09);
    frame_end();

    // One-clk sclk glitch while deselected.
    base = dv_count;
    @(negedge clk); bus.sclk = 1'b1;
    @(negedge clk); bus.sclk = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("glitch_no_pulse", 32'(dv_count - base), 32'd0);
    check_eq("glitch_frame_inactive", 32'(bus.frame_active), 32'h0);
    check_eq("glitch_bit_cnt", 32'(dut.bit_cnt_q), 32'h0);
    frame_start();
    send_bits(8'h3C, 8, mb, lat);
    repeat (4) @(negedge clk);
    check_eq("post_glitch_data", 32'(bus.data_out), 32'h3C);
    frame_end();

    // Asynchronous reset in the middle of a frame.
    bus.tx_data = 8'hFF;
    tx_next     = 8'hFF;
    frame_start();
    check_eq("pre_rst_miso", 32'(bus.miso), 32'h1);
    send_bits(8'hC0, 3, mb, lat);
    check_eq("pre_rst_data_out", 32'(bus.data_out), 32'h3C);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_data_out", 32'(bus.data_out), 32'h00);
    check_eq("mid_rst_data_valid", 32'(bus.data_valid), 32'h0);
    check_eq("mid_rst_miso", 32'(bus.miso), 32'h0);
    check_eq("mid_rst_frame_active", 32'(bus.frame_active), 32'h0);
    bus.cs = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    bus.tx_data = 8'h81;
    tx_next     = 8'h81;
    base        = dv_count;
    frame_start();
    send_bits(8'h7E, 8, mb, lat);
    repeat (4) @(negedge clk);
    check_eq("post_rst_miso", 32'(mb), 32'h81);
    check_eq("post_rst_data", 32'(bus.data_out), 32'h7E);
    check_eq("post_rst_count", 32'(dv_count - base), 32'd1);
    frame_end();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_byte_interface.md
Name: spi_slave_byte_interface

Overview:
SPI mode-0 slave front end sitting directly upstream of spi_control_unit.
- Oversamples the raw SPI pins (sclk, cs, mosi) in the system clock domain.
- Deserialises MSB-first bytes and presents each complete byte on data_out with a one-cycle data_valid pulse; spi_control_unit consumes these pulses for instruction, address and data bytes.
- Serialises tx_data onto miso for read-back.

Parameters:
DATA_WIDTH, 8, bits per SPI word
SYNC_STAGES, 2, flip-flop stages in each input synchroniser (minimum 2)

Ports:
clk  input  1  system clock; must be at least 4x sclk frequency
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
sclk  input  1  raw SPI clock from master
cs  input  1  raw SPI chip select, active-low
mosi  input  1  raw master-out data
miso  output  1  slave-out data
tx_data  input  DATA_WIDTH  byte to transmit; sampled at load points
data_out  output  DATA_WIDTH  last complete received byte
data_valid  output  1  one-clk pulse when data_out is updated
frame_active  output  1  high while synchronised cs is low

Behaviour:
- Reset (reset=0, asynchronous):
  - data_out=0, data_valid=0, miso=0, frame_active=0, bit_cnt=0, rx/tx shift registers=0.
  - Synchroniser flops: sclk chain=0, cs chain=1, mosi chain=0.
- Synchronisers: SYNC_STAGES flops per input; one extra history flop on sclk_s and cs_s for edge detection.
  - sclk_rise = sclk_s & ~sclk_d; sclk_fall = ~sclk_s & sclk_d; cs_fall = ~cs_s & cs_d.
- FSM, two states:
  - IDLE: cs_s=1; miso=0, bit_cnt=0.
  - ACTIVE: cs_s=0.
  - IDLE->ACTIVE on cs_fall: tx_shift<=tx_data, miso<=tx_data[MSB], bit_cnt<=0, frame_active<=1.
  - ACTIVE->IDLE when cs_s=1: the partial byte is discarded with no data_valid; bit_cnt<=0, miso<=0, frame_active<=0. data_out keeps its last value.
- Receive, ACTIVE only, on sclk_rise:
  - rx_shift<={rx_shift[DATA_WIDTH-2:0], mosi_s}; bit_cnt<=bit_cnt+1.
  - If bit_cnt==DATA_WIDTH-1: data_out<={rx_shift[DATA_WIDTH-2:0], mosi_s}, data_valid<=1 on the same clk edge, bit_cnt wraps to 0, reload_pending<=1.
- data_valid is exactly one clk wide.
  - Latency from physical 8th sclk rise to data_valid high: SYNC_STAGES+1 clk (+1 for the registered output).
  - Back-to-back bytes give pulses separated by at least 8 sclk periods; no gap is required between bytes.
- Transmit, ACTIVE only, on sclk_fall:
  - If reload_pending: tx_shift<=tx_data, miso<=tx_data[MSB], reload_pending<=0.
  - Otherwise: tx_shift shifts left, miso<=tx_shift[MSB-1].
  - tx_data must be stable from data_valid until the next sclk_fall.
- Simultaneous events: sclk_rise and sclk_fall cannot occur in the same cycle. A cs_s rise in the same cycle as a completing sclk_rise aborts the byte: cs wins, no data_valid.
- Reset asserted mid-frame: immediate return to reset values. The first frame after reset requires a fresh cs_fall.
- bit_cnt width: $clog2(DATA_WIDTH); wrap-around is explicit, not overflow-dependent.

Decomposition:
- Shared package: DATA_WIDTH default, FSM state encoding (IDLE=0, ACTIVE=1), SPI mode constant (CPOL=0, CPHA=0).
- One sub-module: spi_input_synchronizer (parameterised SYNC_STAGES, parameterised reset value, 1 bit).
  - Instantiated three times: sclk, cs (reset value 1), mosi.

Test Plan:
- Reset with reset=0 mid-frame: data_out=0x00, data_valid=0, miso=0, frame_active=0 immediately, without waiting for a clk edge.
- cs low, shift 0x01 MSB-first at sclk=clk/8: exactly one data_valid pulse, data_out=0x01, pulse 3 clk after the 8th sclk rise.
- Frame of four bytes 0x05, 0xA0, 0x3C, 0x05 back-to-back: four single-cycle pulses in order with matching data_out; spi_control_unit connected downstream asserts clk_div_ready at frame end.
- tx_data=0xA5 at cs_fall, then tx_data=0x5A after the first data_valid: miso samples on sclk rises read 0xA5 then 0x5A.
- Abort: cs raised after 5 bits of 0xFF: no data_valid, data_out unchanged; the next full byte 0x09 is received correctly.
- Glitch immunity: 1-clk-wide sclk pulse with cs high: no state change, bit_cnt=0, data_valid never asserted.
